// File: rtl/crossbar_arb.sv
// crossbar_arb
//
// N_PORTS x N_PORTS registered crossbar switch with a valid/ready handshake on
// every input and every output. Each input carries its own destination index.
// Each output has its own arbiter and a one-entry output register, so every
// output can move one word per cycle. That includes the cycle in which the held
// word drains and a new word loads.
//
// Configuration macro:
//   CROSSBAR_RR_EN  defined   -> round-robin arbitration per output. Each output
//                                keeps a pointer to the input after its last grant.
//                   undefined -> fixed priority. The lowest-indexed requester wins
//                                and no pointer registers exist.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - per-input request
//   in_data    - input i word at [i*WIDTH +: WIDTH]
//   in_dest    - input i target output at [i*DW +: DW]
//   in_ready   - input i word is accepted this cycle (combinational)
//   out_valid  - output register o holds a word
//   out_data   - registered word of output o at [o*WIDTH +: WIDTH]
//   out_src    - index of the input that produced output o's word
//   out_ready  - consumer of output o takes the word this cycle

module crossbar_arb #(
    parameter int  N_PORTS = 4,
    parameter int  WIDTH   = 8,
    localparam int DW      = $clog2(N_PORTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_PORTS-1:0]      in_valid,
    input  logic [N_PORTS*WIDTH-1:0] in_data,
    input  logic [N_PORTS*DW-1:0]   in_dest,
    output logic [N_PORTS-1:0]      in_ready,
    output logic [N_PORTS-1:0]      out_valid,
    output logic [N_PORTS*WIDTH-1:0] out_data,
    output logic [N_PORTS*DW-1:0]   out_src,
    input  logic [N_PORTS-1:0]      out_ready
);

    logic [N_PORTS-1:0] out_free;
    logic [N_PORTS-1:0] gnt_any;
    logic [DW-1:0]      gnt_idx [N_PORTS];
    logic [N_PORTS-1:0] load;

`ifdef CROSSBAR_RR_EN
    logic [DW-1:0]      ptr [N_PORTS];
`endif

    // An output can accept a new word when it is empty, or when its held word
    // leaves this same cycle. This is what gives full throughput under drain.
    assign out_free = ~out_valid | out_ready;
    assign load     = out_free & gnt_any;

    // Per-output arbiter. The search starts at the pointer (round robin) or at
    // input 0 (fixed priority) and wraps. The first matching requester wins.
    // Destinations >= N_PORTS never match any output, so such inputs stall.
    always_comb begin
        int            pos;
        logic [DW-1:0] idx;
        pos = 0;
        idx = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            gnt_any[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int k = 0; k < N_PORTS; k++) begin
`ifdef CROSSBAR_RR_EN
                pos = int'(ptr[o]) + k;
                if (pos >= N_PORTS) begin
                    pos = pos - N_PORTS;
                end
`else
                pos = k;
`endif
                idx = DW'(pos);
                if (!gnt_any[o] && in_valid[idx] &&
                    (in_dest[int'(idx)*DW +: DW] == DW'(o))) begin
                    gnt_any[o] = 1'b1;
                    gnt_idx[o] = idx;
                end
            end
        end
    end

    // An input has exactly one destination, so at most one output can grant it.
    // Holding in_ready low during reset keeps sources from losing words.
    always_comb begin
        in_ready = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (rst_n && load[o]) begin
                in_ready[gnt_idx[o]] = 1'b1;
            end
        end
    end

    // Output registers. A free output either loads the granted word or goes
    // empty. A stalled output keeps its data and src stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                if (out_free[o]) begin
                    out_valid[o] <= gnt_any[o];
                end
                if (load[o]) begin
                    out_data[o*WIDTH +: WIDTH] <= in_data[int'(gnt_idx[o])*WIDTH +: WIDTH];
                    out_src[o*DW +: DW]        <= gnt_idx[o];
                end
            end
        end
    end

`ifdef CROSSBAR_RR_EN
    // After a grant, the pointer moves just past the winner, so the winner has
    // the lowest priority next time. The pointer only moves on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < N_PORTS; o++) begin
                ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                if (load[o]) begin
                    ptr[o] <= (gnt_idx[o] == DW'(N_PORTS - 1)) ? '0 : gnt_idx[o] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_crossbar_arb.sv
// tb_crossbar_arb
//
// Self-checking bench for crossbar_arb with N_PORTS=4 and WIDTH=8.
// A reference model predicts the arbitration result each cycle. Each word it
// expects to be accepted goes into that output's scoreboard queue. While the
// word is presented, the DUT output is compared against the queue head. The
// entry is popped when the consumer takes it. The named scenarios also check
// selected values against constants. Expectations follow CROSSBAR_RR_EN.

module tb_crossbar_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [DW-1:0] src;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N*DW-1:0]  in_dest;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     out_valid;
    logic [N*W-1:0]   out_data;
    logic [N*DW-1:0]  out_src;
    logic [N-1:0]     out_ready;

    exp_t         sbq [N][$];
    int           mptr [N];
    logic [N-1:0] seen_ready;
    int           pass_count = 0;
    int           check_count = 0;

    always #5 clk = ~clk;

    crossbar_arb #(.N_PORTS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // Single comparison point. Every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reset the model state to match a DUT reset.
    task automatic resetModel();
        for (int o = 0; o < N; o++) begin
            sbq[o].delete();
            mptr[o] = 0;
        end
    endtask

    // One cycle of the reference model. Inputs are already driven.
    // Step 1: check the output side against the scoreboard.
    // Step 2: predict the grants and check in_ready.
    // Step 3: queue the words that will load at the next edge.
    task automatic modelCycle();
        logic [N-1:0] free;
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        logic         found;
        int           g;
        int           i;
        int           start;
        exp_t         e;
        free    = '0;
        exp_rdy = '0;
        for (int o = 0; o < N; o++) begin
            exp_v = (sbq[o].size() != 0);
            checkOutput($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(exp_v));
            if (exp_v) begin
                checkOutput($sformatf("out_data[%0d]", o), 32'(out_data[o*W +: W]),
                            32'(sbq[o][0].data));
                checkOutput($sformatf("out_src[%0d]", o), 32'(out_src[o*DW +: DW]),
                            32'(sbq[o][0].src));
            end
            free[o] = !exp_v || out_ready[o];
            if (exp_v && out_ready[o]) begin
                void'(sbq[o].pop_front());
            end
        end
        for (int o = 0; o < N; o++) begin
            found = 1'b0;
            g     = 0;
`ifdef CROSSBAR_RR_EN
            start = mptr[o];
`else
            start = 0;
`endif
            if (free[o]) begin
                for (int k = 0; k < N; k++) begin
                    i = (start + k) % N;
                    if (!found && in_valid[i] && (int'(in_dest[i*DW +: DW]) == o)) begin
                        found = 1'b1;
                        g     = i;
                    end
                end
            end
            if (found) begin
                exp_rdy[g] = 1'b1;
                e.data     = in_data[g*W +: W];
                e.src      = DW'(g);
                sbq[o].push_back(e);
                mptr[o]    = (g + 1) % N;
            end
        end
        seen_ready = in_ready;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    endtask

    // Drive one cycle of stimulus. This is called just after a falling edge and
    // returns at the next falling edge, so the registered outputs are settled.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                 input logic [N*W-1:0] data, input logic [N-1:0] r);
        in_valid  = v;
        in_dest   = d;
        in_data   = data;
        out_ready = r;
        #1;
        modelCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_dest   = '0;
        in_data   = '0;
        out_ready = '0;
        resetModel();

        // Power-on reset with busy inputs: everything stays quiet.
        repeat (2) @(negedge clk);
        in_valid  = 4'hF;
        in_dest   = 8'h1B;
        in_data   = 32'h12345678;
        out_ready = 4'hF;
        #1;
        checkOutput("por_in_ready", 32'(in_ready), 32'h0);
        checkOutput("por_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with random backpressure, checked by the model.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'($urandom), 8'($urandom), $urandom, 4'($urandom));
        end

        // Asynchronous reset between edges, with loaded registers and requests.
        applyStimulus(4'hF, 8'h1B, 32'hDEADBEEF, 4'h0);
        in_valid  = 4'hF;
        in_dest   = 8'($urandom);
        in_data   = $urandom;
        out_ready = 4'($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("arst_out_data", out_data, 32'h0);
        checkOutput("arst_out_src", 32'(out_src), 32'h0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'h0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention on output 1 from inputs 0,1,2. The first grant after
        // reset goes to input 0.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0111, 8'h15, 32'h00332211, 4'hF);
`ifdef CROSSBAR_RR_EN
            checkOutput($sformatf("contend_src_%0d", k), 32'(out_src[3:2]), 32'(k % 3));
`else
            checkOutput($sformatf("contend_src_%0d", k), 32'(out_src[3:2]), 32'h0);
`endif
            checkOutput($sformatf("contend_valid_%0d", k), 32'(out_valid[1]), 32'h1);
        end
        applyStimulus(4'h0, 8'h00, 32'h0, 4'hF);

        // Full permutation: inputs 3..0 go to outputs 0..3.
        applyStimulus(4'hF, 8'h1B, 32'hA3A2A1A0, 4'hF);
        checkOutput("perm_ready", 32'(seen_ready), 32'hF);
        checkOutput("perm_valid", 32'(out_valid), 32'hF);
        checkOutput("perm_data3", 32'(out_data[31:24]), 32'hA0);
        checkOutput("perm_src3", 32'(out_src[7:6]), 32'h0);
        checkOutput("perm_data0", 32'(out_data[7:0]), 32'hA3);
        checkOutput("perm_src0", 32'(out_src[1:0]), 32'h3);

        // Drain to idle: one word to output 0, then no more requests.
        applyStimulus(4'b0001, 8'h00, 32'h0000007E, 4'hF);
        checkOutput("drain_v_hi", 32'(out_valid[0]), 32'h1);
        applyStimulus(4'h0, 8'h00, 32'h0, 4'hF);
        checkOutput("drain_v_lo", 32'(out_valid[0]), 32'h0);

        // Backpressure on output 2. The word is held, then replaced with no bubble.
        applyStimulus(4'b0001, 8'h02, 32'h0000005A, 4'h0);
        applyStimulus(4'b0010, 8'h08, 32'h0000C300, 4'h0);
        checkOutput("bp_ready_low", 32'(seen_ready), 32'h0);
        checkOutput("bp_hold_data", 32'(out_data[23:16]), 32'h5A);
        applyStimulus(4'b0010, 8'h08, 32'h0000C300, 4'b0100);
        checkOutput("bp_ready_high", 32'(seen_ready), 32'b0010);
        checkOutput("bp_new_data", 32'(out_data[23:16]), 32'hC3);
        checkOutput("bp_new_src", 32'(out_src[5:4]), 32'h1);
        checkOutput("bp_new_valid", 32'(out_valid[2]), 32'h1);
        applyStimulus(4'h0, 8'h00, 32'h0, 4'hF);

        // Pointer hold: grant input 2 on output 3, stay idle, then contend 0 vs 3.
        applyStimulus(4'b0100, 8'h30, 32'h00990000, 4'hF);
        repeat (3) applyStimulus(4'h0, 8'h00, 32'h0, 4'hF);
        applyStimulus(4'b1001, 8'hC3, 32'h440000BB, 4'hF);
`ifdef CROSSBAR_RR_EN
        checkOutput("ptr_first", 32'(out_src[7:6]), 32'h3);
`else
        checkOutput("ptr_first", 32'(out_src[7:6]), 32'h0);
`endif
        applyStimulus(4'b1001, 8'hC3, 32'h440000BB, 4'hF);
        checkOutput("ptr_second", 32'(out_src[7:6]), 32'h0);
        applyStimulus(4'h0, 8'h00, 32'h0, 4'hF);
        applyStimulus(4'h0, 8'h00, 32'h0, 4'hF);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/crossbar_arb.md
# crossbar_arb

Parametrised N×N registered crossbar switch with valid/ready handshakes on every input and output. It is the successor to the 2×2 combinational crossbar. Each input carries its own destination index. Each output has a per-output arbiter that resolves contention among inputs and a one-entry output register. It sits between routing sources and downstream consumers in the datapath, and it provides full-throughput, backpressure-aware switching.

## Interface

- `N_PORTS`, 4 — number of input and output ports; must be ≥ 2.
- `WIDTH`, 8 — data width per port.
- `DW`, `$clog2(N_PORTS)` — destination/source index width; derived, not overridden.

Ports:

- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input N_PORTS — per-input request.
- `in_data` input N_PORTS*WIDTH — input i occupies bits [i*WIDTH +: WIDTH].
- `in_dest` input N_PORTS*DW — target output of input i, at [i*DW +: DW].
- `in_ready` output N_PORTS — input i's word is accepted this cycle.
- `out_valid` output N_PORTS — output register o holds a word.
- `out_data` output N_PORTS*WIDTH — registered data for output o.
- `out_src` output N_PORTS*DW — index of the input that produced out_data[o].
- `out_ready` input N_PORTS — consumer of output o takes the word.

## Operation

- Output o is "free" when `!out_valid[o] || out_ready[o]`.
- Requesters of o: every input i with `in_valid[i]` and `in_dest[i] == o`.
- If o is free and has at least one requester, exactly one input g is granted:
  - `in_ready[g]=1`;
  - at the next edge, out_data[o] ← in_data[g], out_src[o] ← g, out_valid[o] ← 1.
- If o is free with no requester, out_valid[o] ← 0 at the next edge.
- If o is not free, the output register holds its data and src stable, and no grant is made.
- in_ready is combinational from in_valid, in_dest, out_valid, out_ready and the arbiter pointers. There is no combinational path from in_data to any output.
- An input targets one output per cycle, so it is never granted twice.
- Destinations ≥ N_PORTS (non-power-of-2 N) match no output: in_ready stays 0 and the input stalls. This is a source error; the block does not flag it.
- Arbitration: each output has a DW-bit pointer `ptr[o]`.
  - The grant goes to the first requester found searching from ptr[o] upward, wrapping at N_PORTS−1 → 0.
  - After a grant to g, ptr[o] ← (g+1) mod N_PORTS.
  - With no grant, ptr[o] is unchanged.
- Outputs are independent: up to N_PORTS transfers complete per cycle (any permutation).

## Timing

- Latency: one cycle from in_valid&in_ready to out_valid at the target output.
- Throughput: one word per output per cycle, including a cycle in which the held word drains (out_ready=1) and a new word loads.
- Reset values, applied immediately on rst_n falling (asynchronous) and held until release:
  - out_valid=0, out_data=0, out_src=0;
  - all ptr=0;
  - in_ready=0 while rst_n=0.
- Reset mid-operation: words in output registers are discarded. The first cycle after release behaves as a post-reset idle state.
- Release of rst_n is assumed synchronous to clk by the surrounding reset synchroniser.

## Configuration

- `CROSSBAR_RR_EN` defined: round-robin arbitration exactly as in Operation.
- `CROSSBAR_RR_EN` undefined:
  - fixed priority, with the lowest-indexed requester winning;
  - ptr registers are not instantiated;
  - all other behaviour, latency and reset values are identical.

## Test plan

All scenarios use N_PORTS=4, WIDTH=8.

- Async reset: drive random inputs, pull rst_n low between edges → out_valid=4'b0000, out_data=0, out_src=0, in_ready=0 immediately. Release → the first contended grant goes to input 0.
- Permutation: in_dest={0,1,2,3} for inputs 3..0, data A0,A1,A2,A3, out_ready=4'hF → in_ready=4'hF in the same cycle. Next cycle out_valid=4'hF, out_data[3]=A0/out_src[3]=0, out_data[0]=A3/out_src[0]=3.
- Contention: inputs 0,1,2 continuously valid to output 1, out_ready=1 →
  - with CROSSBAR_RR_EN, the out_src[1] sequence is 0,1,2,0,1,2 with one word per cycle;
  - without it, the sequence is 0,0,0,….
- Backpressure: out_valid[2]=1 holding 8'h5A, out_ready[2]=0, input 1 requesting output 2 with 8'hC3 → out_data[2] stays 5A and in_ready[1]=0. Raise out_ready[2] → same cycle in_ready[1]=1; next cycle out_data[2]=C3, no bubble.
- Drain to idle: single word to output 0, then in_valid=0 with out_ready[0]=1 → out_valid[0] is high for one cycle, then 0.
- Pointer hold: RR build, grant input 2 on output 3, then 3 idle cycles, then inputs 0 and 3 both request output 3 → input 3 wins first, then input 0.
